// File: rtl/mouse_pkg.sv
// Shared encodings for the PS/2 mouse packet assembler.
// MOUSE_WHEEL_EN selects the 4-byte IntelliMouse packet.
package mouse_pkg;

  localparam int SYNC_BIT = 3;
  localparam int XSIGN    = 4;
  localparam int YSIGN    = 5;
  localparam int XOVF     = 6;
  localparam int YOVF     = 7;

`ifdef MOUSE_WHEEL_EN
  localparam int PKT_LEN = 4;
  typedef enum logic [2:0] {
    WAIT_B1,
    WAIT_B2,
    WAIT_B3,
    WAIT_B4,
    COMMIT
  } state_t;
`else
  localparam int PKT_LEN = 3;
  typedef enum logic [2:0] {
    WAIT_B1,
    WAIT_B2,
    WAIT_B3,
    COMMIT
  } state_t;
`endif

  // Overflowed axes saturate to the extreme 9-bit value
  function automatic logic [8:0] decode_delta(
    input logic       sgn,
    input logic       ovf,
    input logic [7:0] mag
  );
    if (ovf)
      return sgn ? 9'h100 : 9'h0FF;
    return {sgn, mag};
  endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// One screen axis: position plus signed delta,
// clamped to [0, MAX] without wrap-around.
module mouse_axis_clamp #(
  parameter int POS_W = 8,
  parameter int MAX   = 159,
  parameter int DW    = 9
) (
  input  logic [POS_W-1:0]    pos,
  input  logic signed [DW-1:0] delta,
  output logic [POS_W-1:0]    pos_next
);

  localparam int SW = POS_W + 2;

  logic signed [SW-1:0] d_ext;
  logic signed [SW-1:0] sum;

  always_comb begin
    d_ext = SW'(delta);
    sum   = $signed({2'b00, pos}) + d_ext;
    if (sum[SW-1])
      pos_next = '0;
    else if (sum > $signed(SW'(MAX)))
      pos_next = POS_W'(MAX);
    else
      pos_next = sum[POS_W-1:0];
  end

endmodule

// File: rtl/mouse_packet_assembler.sv
// Assembles PS/2 mouse packets into deltas and clamped position.
// Define MOUSE_WHEEL_EN for the 4-byte wheel packet.
module mouse_packet_assembler
  import mouse_pkg::*;
#(
  parameter int X_MAX          = 159,
  parameter int Y_MAX          = 119,
  parameter int POS_W          = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic             READ_ENABLE,
  input  logic [7:0]       BYTE_READ,
  input  logic [1:0]       BYTE_ERROR_CODE,
  input  logic             BYTE_READY,
  output logic [7:0]       STATUS,
  output logic [8:0]       DX,
  output logic [8:0]       DY,
  output logic [3:0]       DZ,
  output logic [POS_W-1:0] MOUSE_X,
  output logic [POS_W-1:0] MOUSE_Y,
  output logic             PACKET_VALID,
  output logic [7:0]       ERR_COUNT
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] b1_q, b2_q, b3_q;
`ifdef MOUSE_WHEEL_EN
  logic [3:0] b4_q;
  logic       lat4;
`endif
  logic lat1, lat2, lat3;
  logic err_inc, commit;
  logic ok_byte, bad_byte, expired;

  logic        [8:0] dx_dec, dy_dec;
  logic signed [9:0] dy_neg;
  logic [POS_W-1:0]  x_next, y_next;

  assign ok_byte  = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  assign bad_byte = BYTE_READY && (BYTE_ERROR_CODE != 2'b00);
  assign expired  = timer_q == TW'(TIMEOUT_CYCLES - 1);

  // Byte arriving on the expiry cycle takes priority over the timeout
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    err_inc = 1'b0;
    commit  = 1'b0;
    lat1    = 1'b0;
    lat2    = 1'b0;
    lat3    = 1'b0;
`ifdef MOUSE_WHEEL_EN
    lat4    = 1'b0;
`endif
    unique case (state_q)
      WAIT_B1, COMMIT: begin
        commit  = state_q == COMMIT;
        state_d = WAIT_B1;
        if (bad_byte) begin
          err_inc = 1'b1;
        end else if (ok_byte && BYTE_READ[SYNC_BIT]) begin
          lat1    = 1'b1;
          state_d = WAIT_B2;
        end
      end
      WAIT_B2: begin
        if (bad_byte) begin
          err_inc = 1'b1;
          state_d = WAIT_B1;
        end else if (ok_byte) begin
          lat2    = 1'b1;
          state_d = WAIT_B3;
        end else if (expired) begin
          err_inc = 1'b1;
          state_d = WAIT_B1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_B3: begin
        if (bad_byte) begin
          err_inc = 1'b1;
          state_d = WAIT_B1;
        end else if (ok_byte) begin
          lat3    = 1'b1;
`ifdef MOUSE_WHEEL_EN
          state_d = WAIT_B4;
`else
          state_d = COMMIT;
`endif
        end else if (expired) begin
          err_inc = 1'b1;
          state_d = WAIT_B1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef MOUSE_WHEEL_EN
      WAIT_B4: begin
        if (bad_byte) begin
          err_inc = 1'b1;
          state_d = WAIT_B1;
        end else if (ok_byte) begin
          lat4    = 1'b1;
          state_d = COMMIT;
        end else if (expired) begin
          err_inc = 1'b1;
          state_d = WAIT_B1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      default: state_d = WAIT_B1;
    endcase
  end

  always_comb begin
    dx_dec = decode_delta(b1_q[XSIGN], b1_q[XOVF], b2_q);
    dy_dec = decode_delta(b1_q[YSIGN], b1_q[YOVF], b3_q);
    dy_neg = -$signed({dy_dec[8], dy_dec});
  end

  mouse_axis_clamp #(
    .POS_W (POS_W),
    .MAX   (X_MAX),
    .DW    (9)
  ) u_clamp_x (
    .pos      (MOUSE_X),
    .delta    ($signed(dx_dec)),
    .pos_next (x_next)
  );

  // Screen Y grows downward, PS/2 Y grows upward
  mouse_axis_clamp #(
    .POS_W (POS_W),
    .MAX   (Y_MAX),
    .DW    (10)
  ) u_clamp_y (
    .pos      (MOUSE_Y),
    .delta    (dy_neg),
    .pos_next (y_next)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      READ_ENABLE  <= 1'b0;
      state_q      <= WAIT_B1;
      timer_q      <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
      b3_q         <= '0;
`ifdef MOUSE_WHEEL_EN
      b4_q         <= '0;
`endif
      STATUS       <= '0;
      DX           <= '0;
      DY           <= '0;
      DZ           <= '0;
      MOUSE_X      <= POS_W'(X_MAX >> 1);
      MOUSE_Y      <= POS_W'(Y_MAX >> 1);
      PACKET_VALID <= 1'b0;
      ERR_COUNT    <= '0;
    end else begin
      READ_ENABLE  <= 1'b1;
      state_q      <= state_d;
      timer_q      <= timer_d;
      PACKET_VALID <= commit;
      if (lat1) b1_q <= BYTE_READ;
      if (lat2) b2_q <= BYTE_READ;
      if (lat3) b3_q <= BYTE_READ;
`ifdef MOUSE_WHEEL_EN
      if (lat4) b4_q <= BYTE_READ[3:0];
`endif
      if (err_inc && ERR_COUNT != 8'hFF)
        ERR_COUNT <= ERR_COUNT + 8'd1;
      if (commit) begin
        STATUS  <= b1_q;
        DX      <= dx_dec;
        DY      <= dy_dec;
`ifdef MOUSE_WHEEL_EN
        DZ      <= b4_q;
`else
        DZ      <= 4'd0;
`endif
        MOUSE_X <= x_next;
        MOUSE_Y <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_assembler.sv
// Randomised bench for mouse_packet_assembler against a
// packet-level reference model.
module tb_mouse_packet_assembler;
  import mouse_pkg::*;

  localparam int TO   = 200;
  localparam int XMAX = 159;
  localparam int YMAX = 119;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = '0;
  logic [1:0] BYTE_ERROR_CODE = '0;
  logic       BYTE_READY = 1'b0;
  logic [7:0] STATUS;
  logic [8:0] DX, DY;
  logic [3:0] DZ;
  logic [7:0] MOUSE_X, MOUSE_Y;
  logic       PACKET_VALID;
  logic [7:0] ERR_COUNT;

  mouse_packet_assembler #(
    .X_MAX          (XMAX),
    .Y_MAX          (YMAX),
    .POS_W          (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .READ_ENABLE     (READ_ENABLE),
    .BYTE_READ       (BYTE_READ),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
    .BYTE_READY      (BYTE_READY),
    .STATUS          (STATUS),
    .DX              (DX),
    .DY              (DY),
    .DZ              (DZ),
    .MOUSE_X         (MOUSE_X),
    .MOUSE_Y         (MOUSE_Y),
    .PACKET_VALID    (PACKET_VALID),
    .ERR_COUNT       (ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] st;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [3:0] dz;
    int         x;
    int         y;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         mx, my, merr, nb;
  logic [7:0] pk[4];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int delta_of(input logic sgn, input logic ovf,
                                  input logic [7:0] mag);
    if (ovf) return sgn ? -256 : 255;
    return sgn ? int'(mag) - 256 : int'(mag);
  endfunction

  task automatic model_commit(input int now);
    exp_t e;
    int dx, dy;
    dx = delta_of(pk[0][4], pk[0][6], pk[1]);
    dy = delta_of(pk[0][5], pk[0][7], pk[2]);
    mx = clampi(mx + dx, XMAX);
    my = clampi(my - dy, YMAX);
    e.cyc = now + 2;
    e.st  = pk[0];
    e.dx  = dx[8:0];
    e.dy  = dy[8:0];
`ifdef MOUSE_WHEEL_EN
    e.dz  = pk[3][3:0];
`else
    e.dz  = 4'd0;
`endif
    e.x   = mx;
    e.y   = my;
    q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [1:0] e,
                            input int now);
    if (e != 2'b00) begin
      if (merr < 255) merr++;
      nb = 0;
    end else if (nb == 0) begin
      if (b[3]) begin
        pk[0] = b;
        nb = 1;
      end
    end else begin
      pk[nb] = b;
      nb++;
      if (nb == PKT_LEN) begin
        model_commit(now);
        nb = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [1:0] e);
    BYTE_READ = b;
    BYTE_ERROR_CODE = e;
    BYTE_READY = 1'b1;
    model_byte(b, e, cyc);
    @(posedge CLK); #1;
    BYTE_READY = 1'b0;
    BYTE_READ = 8'($urandom);
    BYTE_ERROR_CODE = 2'($urandom);
  endtask

  task automatic idle(input int n);
    if (nb > 0 && n >= TO) begin
      if (merr < 255) merr++;
      nb = 0;
    end
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic pkt(input logic [7:0] b1, input logic [7:0] b2,
                     input logic [7:0] b3, input logic [7:0] b4);
    send_byte(b1, 2'b00); idle(1);
    send_byte(b2, 2'b00); idle(1);
    send_byte(b3, 2'b00);
`ifdef MOUSE_WHEEL_EN
    idle(1);
    send_byte(b4, 2'b00);
`endif
    idle(4);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    BYTE_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    q.delete();
    mx = XMAX >> 1;
    my = YMAX >> 1;
    merr = 0;
    nb = 0;
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        chk("pv", 32'(PACKET_VALID), 32'd1);
        chk("status", 32'(STATUS), 32'(q[0].st));
        chk("dx", 32'(DX), 32'(q[0].dx));
        chk("dy", 32'(DY), 32'(q[0].dy));
        chk("dz", 32'(DZ), 32'(q[0].dz));
        chk("mouse_x", 32'(MOUSE_X), 32'(q[0].x));
        chk("mouse_y", 32'(MOUSE_Y), 32'(q[0].y));
        void'(q.pop_front());
      end else if (PACKET_VALID) begin
        chk("pv_spurious", 32'(PACKET_VALID), 32'd0);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [1:0] e;

    do_reset();
    chk("rst_re", 32'(READ_ENABLE), 32'd0);
    chk("rst_pv", 32'(PACKET_VALID), 32'd0);
    chk("rst_status", 32'(STATUS), 32'd0);
    chk("rst_dx", 32'(DX), 32'd0);
    chk("rst_err", 32'(ERR_COUNT), 32'd0);
    chk("rst_x", 32'(MOUSE_X), 32'd79);
    chk("rst_y", 32'(MOUSE_Y), 32'd59);
    idle(1);
    chk("re_on", 32'(READ_ENABLE), 32'd1);

    pkt(8'h08, 8'h05, 8'h03, 8'h00);
    chk("t1_dx", 32'(DX), 32'd5);
    chk("t1_dy", 32'(DY), 32'd3);
    chk("t1_x", 32'(MOUSE_X), 32'd84);
    chk("t1_y", 32'(MOUSE_Y), 32'd56);

    pkt(8'h18, 8'hAE, 8'h00, 8'h00);
    chk("t2_x2", 32'(MOUSE_X), 32'd2);
    pkt(8'h18, 8'hFB, 8'h00, 8'h00);
    chk("t2_dxneg", 32'(DX), 32'h1FB);
    chk("t2_xlo", 32'(MOUSE_X), 32'd0);
    pkt(8'hC8, 8'h00, 8'h00, 8'h00);
    chk("t2_dxovf", 32'(DX), 32'd255);
    chk("t2_xhi", 32'(MOUSE_X), 32'd159);
    chk("t2_ylo", 32'(MOUSE_Y), 32'd0);

    send_byte(8'h00, 2'b00); idle(2);
    pkt(8'h09, 8'h01, 8'h01, 8'h00);
    chk("t3_status", 32'(STATUS), 32'h09);
    chk("t3_err", 32'(ERR_COUNT), 32'd0);

    send_byte(8'h08, 2'b00); idle(1);
    send_byte(8'h05, 2'b01); idle(3);
    chk("t4_err", 32'(ERR_COUNT), 32'd1);
    pkt(8'h08, 8'h01, 8'h00, 8'h00);
    chk("t4_dx", 32'(DX), 32'd1);

    do_reset();
    send_byte(8'h08, 2'b00);
    send_byte(8'h01, 2'b00);
    idle(TO);
    chk("t5_err", 32'(ERR_COUNT), 32'd1);
    pkt(8'h08, 8'h02, 8'h00, 8'h00);
    chk("t5_dx", 32'(DX), 32'd2);
    send_byte(8'h08, 2'b00);
    send_byte(8'h03, 2'b00);
    idle(TO - 1);
    send_byte(8'h00, 2'b00);
`ifdef MOUSE_WHEEL_EN
    send_byte(8'h00, 2'b00);
`endif
    idle(4);
    chk("t5_edge_err", 32'(ERR_COUNT), 32'd1);
    chk("t5_edge_dx", 32'(DX), 32'd3);

`ifdef MOUSE_WHEEL_EN
    pkt(8'h08, 8'h00, 8'h00, 8'h0F);
    chk("t6_dz", 32'(DZ), 32'hF);
`endif
    send_byte(8'h08, 2'b00);
    send_byte(8'h05, 2'b00);
    do_reset();
    idle(5);
    chk("mid_rst_x", 32'(MOUSE_X), 32'd79);
    chk("mid_rst_y", 32'(MOUSE_Y), 32'd59);

    for (int p = 0; p < 300; p++) begin
      for (int i = 0; i < PKT_LEN; i++) begin
        b = 8'($urandom);
        if (i == 0) begin
          b[3] = ($urandom_range(0, 9) != 0);
          if ($urandom_range(0, 7) != 0) b[7:6] = 2'b00;
        end
        e = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3))
                                         : 2'b00;
        send_byte(b, e);
        idle($urandom_range(0, 3));
      end
    end
    idle(6);
    chk("rnd_err", 32'(ERR_COUNT), 32'(merr));
    chk("rnd_x", 32'(MOUSE_X), 32'(mx));
    chk("rnd_y", 32'(MOUSE_Y), 32'(my));

    do_reset();
    for (int i = 0; i < 260; i++) send_byte(8'($urandom), 2'b10);
    idle(2);
    chk("sat_err", 32'(ERR_COUNT), 32'd255);
    chk("sat_model", 32'(ERR_COUNT), 32'(merr));
    chk("pending", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
